clasificador_pulsacion: RTL and testbench

Classifies the debounced button level from the debouncer stage into single-cycle event pulses: short press, double press, long press and auto-repeat while held. It sits directly downstream of the debouncer and upstream of the control logic, which only ever sees one-cycle pulses. The input is already synchronized and glitch-free; this block adds no synchronizer.

---
 rtl/clasificador_pulsacion_pkg.sv | 28 ++
 rtl/clasificador_pulsacion_if.sv | 28 ++
 rtl/clasificador_pulsacion_detector_flanco.sv | 19 +
 rtl/clasificador_pulsacion.sv | 132 +++++++++++++
 tb/tb_clasificador_pulsacion.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/clasificador_pulsacion_pkg.sv
// clasificador_pulsacion shared constants
// Clock frequency, ms-to-cycles helper and default timing thresholds.
package clasificador_pulsacion_pkg;

  localparam int unsigned FREQ_CLK = 20_000_000;
  localparam int unsigned CICLOS_POR_MS = FREQ_CLK / 1000;

  function automatic int unsigned ms_a_ciclos(input int unsigned ms);
    return CICLOS_POR_MS * ms;
  endfunction

  function automatic int unsigned max3(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  localparam int unsigned LONG_DEF   = ms_a_ciclos(1000);
  localparam int unsigned DOBLE_DEF  = ms_a_ciclos(300);
  localparam int unsigned REPEAT_DEF = ms_a_ciclos(200);

endpackage

// File: rtl/clasificador_pulsacion_if.sv
// clasificador_pulsacion button/event bundle
// master drives the button level, slave returns the event pulses.
interface clasificador_pulsacion_if;
  logic btn_limpio;
  logic pulso_corto;
  logic pulso_doble;
  logic pulso_largo;
  logic pulso_rep;
  logic ocupado;

  modport master (
    output btn_limpio,
    input  pulso_corto,
    input  pulso_doble,
    input  pulso_largo,
    input  pulso_rep,
    input  ocupado
  );

  modport slave (
    input  btn_limpio,
    output pulso_corto,
    output pulso_doble,
    output pulso_largo,
    output pulso_rep,
    output ocupado
  );
endinterface

// File: rtl/clasificador_pulsacion_detector_flanco.sv
// Edge detector on an already synchronized level
// prev_q tracks the input every cycle, reset included.
module clasificador_pulsacion_detector_flanco (
  input  logic clk,
  input  logic d_i,
  output logic sube_o,
  output logic baja_o
);
  logic prev_q;

  // Reset deliberately absent: loading the live level keeps a held
  // button from looking like a fresh press after reset.
  always_ff @(posedge clk) begin
    prev_q <= d_i;
  end

  assign sube_o = d_i & ~prev_q;
  assign baja_o = ~d_i & prev_q;
endmodule

// File: rtl/clasificador_pulsacion.sv
// clasificador_pulsacion: debounced level -> one-cycle press events
// Short, double, long and auto-repeat classification with one counter.
module clasificador_pulsacion
  import clasificador_pulsacion_pkg::*;
#(
  parameter int unsigned LONG_COUNT   = LONG_DEF,
  parameter int unsigned DOBLE_COUNT  = DOBLE_DEF,
  parameter int unsigned REPEAT_COUNT = REPEAT_DEF
) (
  input logic clk,
  input logic rst,
  clasificador_pulsacion_if.slave bus
);

  localparam int unsigned CW =
    $clog2(max3(LONG_COUNT, DOBLE_COUNT, REPEAT_COUNT)) + 1;

  localparam logic [CW-1:0] LONG_FIN  = CW'(LONG_COUNT - 1);
  localparam logic [CW-1:0] DOBLE_FIN = CW'(DOBLE_COUNT - 1);
  localparam logic [CW-1:0] REP_FIN   = CW'(REPEAT_COUNT - 1);

  typedef enum logic [2:0] {
    REPOSO       = 3'd0,
    PRESIONADO   = 3'd1,
    LARGO        = 3'd2,
    ESPERA_DOBLE = 3'd3,
    SEGUNDA      = 3'd4
  } estado_t;

  estado_t       estado_q;
  logic [CW-1:0] cnt_q;
  logic          corto_q;
  logic          doble_q;
  logic          largo_q;
  logic          rep_q;
  logic          ocupado_q;
  logic          sube;
  logic          baja;

  clasificador_pulsacion_detector_flanco u_flanco (
    .clk    (clk),
    .d_i    (bus.btn_limpio),
    .sube_o (sube),
    .baja_o (baja)
  );

  // Classifier FSM, shared counter and registered event outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= REPOSO;
      cnt_q     <= '0;
      corto_q   <= 1'b0;
      doble_q   <= 1'b0;
      largo_q   <= 1'b0;
      rep_q     <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      corto_q <= 1'b0;
      doble_q <= 1'b0;
      largo_q <= 1'b0;
      rep_q   <= 1'b0;
      unique case (estado_q)
        REPOSO: begin
          if (sube) begin
            estado_q  <= PRESIONADO;
            cnt_q     <= '0;
            ocupado_q <= 1'b1;
          end
        end
        PRESIONADO: begin
          if (cnt_q == LONG_FIN) begin
            largo_q  <= 1'b1;
            estado_q <= LARGO;
            cnt_q    <= '0;
          end else if (baja) begin
            estado_q <= ESPERA_DOBLE;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LARGO: begin
          if (cnt_q == REP_FIN) begin
            rep_q <= 1'b1;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
          // Level, not edge: a release that coincided with the long
          // threshold has already been consumed by PRESIONADO.
          if (!bus.btn_limpio) begin
            estado_q  <= REPOSO;
            cnt_q     <= '0;
            ocupado_q <= 1'b0;
          end
        end
        ESPERA_DOBLE: begin
          if (sube) begin
            doble_q  <= 1'b1;
            estado_q <= SEGUNDA;
            cnt_q    <= '0;
          end else if (cnt_q == DOBLE_FIN) begin
            corto_q   <= 1'b1;
            estado_q  <= REPOSO;
            cnt_q     <= '0;
            ocupado_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SEGUNDA: begin
          if (baja) begin
            estado_q  <= REPOSO;
            ocupado_q <= 1'b0;
          end
        end
        default: begin
          estado_q  <= REPOSO;
          cnt_q     <= '0;
          ocupado_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pulso_corto = corto_q;
  assign bus.pulso_doble = doble_q;
  assign bus.pulso_largo = largo_q;
  assign bus.pulso_rep   = rep_q;
  assign bus.ocupado     = ocupado_q;

endmodule

// File: tb/tb_clasificador_pulsacion.sv
// tb_clasificador_pulsacion: scenario table, reset sequences, random run
// Every cycle is also checked against a timestamp-based reference model.
module tb_clasificador_pulsacion;

  localparam int L = 20;
  localparam int D = 8;
  localparam int R = 5;

  localparam int P_IDLE = 0;
  localparam int P_HELD = 1;
  localparam int P_LONG = 2;
  localparam int P_WAIT = 3;
  localparam int P_SEC  = 4;

  logic clk;
  logic rst;

  clasificador_pulsacion_if bus();

  clasificador_pulsacion #(
    .LONG_COUNT   (L),
    .DOBLE_COUNT  (D),
    .REPEAT_COUNT (R)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc_n  = 0;

  int   ph     = P_IDLE;
  int   anchor = 0;
  logic prv    = 1'b0;
  logic [4:0] exp_v;

  int c_cnt, d_cnt, l_cnt, r_cnt, first_t;

  typedef struct {
    int h1;
    int gap;
    int h2;
    int n_c;
    int n_d;
    int n_l;
    int n_r;
    int t_first;
  } esc_t;

  esc_t tabla[9];

  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, got, want);
  endtask

  // Reference model: time anchors instead of a counter; expected
  // outputs after the edge that samples (b, r) at cycle t.
  task automatic model(input logic b, input logic r, input int t);
    logic rise, fall, c, d, l, p;
    rise = b & ~prv;
    fall = ~b & prv;
    c = 0; d = 0; l = 0; p = 0;
    prv = b;
    if (r) begin
      ph = P_IDLE;
    end else begin
      case (ph)
        P_IDLE: if (rise) begin ph = P_HELD; anchor = t + 1; end
        P_HELD:
          if (t - anchor == L - 1) begin
            l = 1; ph = P_LONG; anchor = t + 1;
          end else if (fall) begin
            ph = P_WAIT; anchor = t + 1;
          end
        P_LONG: begin
          if ((t - anchor) % R == R - 1) p = 1;
          if (!b) ph = P_IDLE;
        end
        P_WAIT:
          if (rise) begin
            d = 1; ph = P_SEC;
          end else if (t - anchor == D - 1) begin
            c = 1; ph = P_IDLE;
          end
        P_SEC: if (fall) ph = P_IDLE;
        default: ph = P_IDLE;
      endcase
    end
    exp_v = {c, d, l, p, logic'(ph != P_IDLE)};
  endtask

  task automatic cyc(input logic b, input logic r);
    logic [4:0] got;
    int k;
    k = cyc_n;
    bus.btn_limpio = b;
    rst = r;
    model(b, r, k);
    @(posedge clk);
    @(negedge clk);
    got = {bus.pulso_corto, bus.pulso_doble, bus.pulso_largo,
           bus.pulso_rep, bus.ocupado};
    n_chk++;
    if (got === exp_v) n_pass++;
    else $display("FAIL model cyc %0d: got %b want %b", k, got, exp_v);
    if (got[4]) c_cnt++;
    if (got[3]) d_cnt++;
    if (got[2]) l_cnt++;
    if (got[1]) r_cnt++;
    if (got[4:1] != 4'b0 && first_t < 0) first_t = k + 1;
    cyc_n++;
  endtask

  task automatic clr();
    c_cnt = 0; d_cnt = 0; l_cnt = 0; r_cnt = 0; first_t = -1;
  endtask

  function automatic int total();
    return c_cnt + d_cnt + l_cnt + r_cnt;
  endfunction

  task automatic escenario(input int i, input esc_t e);
    int t0;
    repeat (3) cyc(1'b0, 1'b0);
    clr();
    t0 = cyc_n;
    repeat (e.h1) cyc(1'b1, 1'b0);
    repeat (e.gap) cyc(1'b0, 1'b0);
    repeat (e.h2) cyc(1'b1, 1'b0);
    repeat (30) cyc(1'b0, 1'b0);
    chk($sformatf("esc%0d corto", i), c_cnt, e.n_c);
    chk($sformatf("esc%0d doble", i), d_cnt, e.n_d);
    chk($sformatf("esc%0d largo", i), l_cnt, e.n_l);
    chk($sformatf("esc%0d rep", i), r_cnt, e.n_r);
    chk($sformatf("esc%0d first", i), first_t - t0, e.t_first);
  endtask

  initial begin
    rst = 1'b1;
    bus.btn_limpio = 1'b0;
    clr();

    //           h1  gap h2  c  d  l  r  first
    tabla[0] = '{5,  0,  0,  1, 0, 0, 0, 14};
    tabla[1] = '{5,  3,  4,  0, 1, 0, 0, 9};
    tabla[2] = '{40, 0,  0,  0, 0, 1, 4, 21};
    tabla[3] = '{5,  9,  4,  2, 0, 0, 0, 14};
    tabla[4] = '{5,  8,  4,  0, 1, 0, 0, 14};
    tabla[5] = '{20, 0,  0,  0, 0, 1, 0, 21};
    tabla[6] = '{19, 0,  0,  1, 0, 0, 0, 28};
    tabla[7] = '{21, 0,  0,  0, 0, 1, 0, 21};
    tabla[8] = '{5,  2,  25, 0, 1, 0, 0, 8};

    @(negedge clk);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("reset ocupado", int'(bus.ocupado), 0);
    chk("reset pulses", int'({bus.pulso_corto, bus.pulso_doble,
                              bus.pulso_largo, bus.pulso_rep}), 0);

    for (int i = 0; i < 9; i++) escenario(i, tabla[i]);

    // reset while in PRESIONADO
    repeat (3) cyc(1'b0, 1'b0);
    clr();
    repeat (10) cyc(1'b1, 1'b0);
    chk("pre-rst ocupado", int'(bus.ocupado), 1);
    cyc(1'b1, 1'b1);
    chk("rst mid ocupado", int'(bus.ocupado), 0);
    repeat (5) cyc(1'b1, 1'b0);
    repeat (30) cyc(1'b0, 1'b0);
    chk("rst mid no pulse", total(), 0);

    // button held through reset
    clr();
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    repeat (30) cyc(1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b0);
    chk("held rst no event", total(), 0);
    repeat (5) cyc(1'b1, 1'b0);
    repeat (30) cyc(1'b0, 1'b0);
    chk("held rst then corto", c_cnt, 1);

    // reset while waiting for a second press
    clr();
    repeat (5) cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    repeat (20) cyc(1'b0, 1'b0);
    chk("rst wait no corto", total(), 0);

    // random level runs with rare resets
    begin
      logic b;
      b = 1'b0;
      repeat (150) begin
        int n;
        n = $urandom_range(1, 30);
        b = ~b;
        repeat (n) cyc(b, logic'($urandom_range(0, 199) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
